// File: rtl/kem_sample_ntt_pkg.sv
// Shared ML-KEM types and constants.
// Sampler state, SHAKE128 block layout and field parameters.
package TYPES_KEM;

  localparam int          ML_KEM_LEN_Q = 12;
  localparam logic [11:0] ML_KEM_Q     = 12'd3329;
  localparam int          ML_KEM_N     = 256;

  localparam int SHAKE128_RATE_BYTES = 168;

  typedef logic [SHAKE128_RATE_BYTES-1:0][7:0] shake128_blk_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BLK = 2'd1,
    PARSE    = 2'd2,
    DONE     = 2'd3
  } kem_sample_state_t;

endpackage

// File: rtl/kem_sample_ntt_parse.sv
// Candidate extractor for SampleNTT.
// Selects triplet k>>1 and forms the 12-bit candidate.
module kem_sample_ntt_parse
  import TYPES_KEM::*;
(
  input  shake128_blk_t           i_blk,
  input  logic [6:0]              i_k,
  output logic [ML_KEM_LEN_Q-1:0] o_d,
  output logic                    o_accept
);

  logic [7:0] w_t;
  logic [7:0] w_base;
  logic [7:0] w_b0;
  logic [7:0] w_b1;
  logic [7:0] w_b2;

  assign w_t    = {2'b00, i_k[6:1]};
  assign w_base = w_t * 8'd3;

  // Byte select for the current triplet.
  always_comb begin
    w_b0 = i_blk[w_base];
    w_b1 = i_blk[w_base + 8'd1];
    w_b2 = i_blk[w_base + 8'd2];
  end

  // Odd candidates use the high nibble of b1 and all of b2.
  always_comb begin
    o_d = '0;
    unique case (1'b1)
      i_k[0]:  o_d = {w_b2, w_b1[7:4]};
      default: o_d = {w_b1[3:0], w_b0};
    endcase
    o_accept = (o_d < ML_KEM_Q);
  end

endmodule

// File: rtl/kem_sample_ntt.sv
// SampleNTT rejection sampler.
// Turns SHAKE128 rate blocks into 256 coefficients < q.
module kem_sample_ntt
  import TYPES_KEM::*;
(
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic                             blk_valid_i,
  input  logic [8*SHAKE128_RATE_BYTES-1:0] blk_i,
  output logic                             blk_ready_o,
  output logic                             coef_valid_o,
  input  logic                             coef_ready_i,
  output logic [ML_KEM_LEN_Q-1:0]          coef_o,
  output logic [7:0]                       coef_idx_o,
  output logic                             busy_o,
  output logic                             done_o
);

  localparam int          RATE_BYTES = SHAKE128_RATE_BYTES;
  localparam int          N_CAND     = 2 * RATE_BYTES / 3;
  localparam logic [6:0]  K_LAST     = 7'(N_CAND - 1);
  localparam logic [8:0]  N_LAST     = 9'(ML_KEM_N - 1);

  kem_sample_state_t r_state;
  shake128_blk_t     r_blk;
  logic [6:0]        r_k;
  logic [8:0]        r_n;

  logic [ML_KEM_LEN_Q-1:0] w_d;
  logic                    w_accept;
  logic                    w_valid;

  kem_sample_ntt_parse u_parse (
    .i_blk    (r_blk),
    .i_k      (r_k),
    .o_d      (w_d),
    .o_accept (w_accept)
  );

  // Block register: loaded only on the block handshake.
  always_ff @(posedge clk_i) begin
    if (r_state == WAIT_BLK && blk_valid_i) begin
      r_blk <= blk_i;
    end
  end

  // Sampler control: state, candidate index and accepted count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_n     <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start_i) begin
            r_state <= WAIT_BLK;
            r_n     <= '0;
          end
        end
        WAIT_BLK: begin
          if (blk_valid_i) begin
            r_state <= PARSE;
            r_k     <= '0;
          end
        end
        PARSE: begin
          if (w_accept) begin
            if (coef_ready_i) begin
              r_n <= r_n + 9'd1;
              r_k <= r_k + 7'd1;
              if (r_n == N_LAST) begin
                r_state <= DONE;
              end else if (r_k == K_LAST) begin
                r_state <= WAIT_BLK;
              end
            end
          end else begin
            r_k <= r_k + 7'd1;
            if (r_k == K_LAST) begin
              r_state <= WAIT_BLK;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign w_valid      = (r_state == PARSE) && w_accept;
  assign coef_valid_o = w_valid;
  assign coef_o       = w_valid ? w_d : '0;
  assign coef_idx_o   = w_valid ? r_n[7:0] : '0;
  assign blk_ready_o  = (r_state == WAIT_BLK);
  assign busy_o       = (r_state != IDLE);
  assign done_o       = (r_state == DONE);

endmodule

// File: tb/tb_kem_sample_ntt.sv
// Directed bench for kem_sample_ntt.
// Hand vectors plus a small reference stream model.
module tb_kem_sample_ntt;

  logic          clk;
  logic          rst;
  logic          start;
  logic          blk_valid;
  logic [1343:0] blk;
  logic          blk_ready;
  logic          coef_valid;
  logic          coef_ready;
  logic [11:0]   coef;
  logic [7:0]    coef_idx;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  logic [1343:0] src[$];
  logic [11:0]   expq[$];
  int            model_cnt;
  int            nidx;

  kem_sample_ntt dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .blk_valid_i  (blk_valid),
    .blk_i        (blk),
    .blk_ready_o  (blk_ready),
    .coef_valid_o (coef_valid),
    .coef_ready_i (coef_ready),
    .coef_o       (coef),
    .coef_idx_o   (coef_idx),
    .busy_o       (busy),
    .done_o       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_blk_ready"}, 32'(blk_ready), 32'd0);
    chk({tag, "_valid"}, 32'(coef_valid), 32'd0);
    chk({tag, "_coef"}, 32'(coef), 32'd0);
    chk({tag, "_idx"}, 32'(coef_idx), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    blk_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic start_poly();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ready_after_start", 32'(blk_ready), 32'd1);
  endtask

  // Reference: accepted candidates of one block, capped at 256.
  task automatic model_push(input logic [1343:0] b);
    logic [7:0]  b0, b1, b2;
    logic [11:0] d;
    for (int k = 0; k < 112; k++) begin
      b0 = b[24*(k/2) +: 8];
      b1 = b[24*(k/2) + 8 +: 8];
      b2 = b[24*(k/2) + 16 +: 8];
      if (k % 2 == 0) d = 12'(b0) + 12'(256 * (b1 & 8'h0F));
      else            d = 12'(b1 >> 4) + 12'(16 * b2);
      if (d < 12'd3329 && model_cnt < 256) begin
        expq.push_back(d);
        model_cnt++;
      end
    end
  endtask

  function automatic logic [1343:0] rand_blk();
    logic [1343:0] b;
    for (int j = 0; j < 42; j++) b[32*j +: 32] = $urandom;
    return b;
  endfunction

  task automatic new_poly();
    src.delete();
    expq.delete();
    model_cnt = 0;
    nidx = 0;
  endtask

  // Drive blocks from src, consume coefficients, check vs expq.
  task automatic stream(input int pct, input int stop_n,
                        input bit noise, input int max_cyc);
    int          hs;
    bit          fin;
    bit          took;
    logic        pv, pr;
    logic [11:0] pc;
    logic [7:0]  pi;
    hs = 0; fin = 1'b0; pv = 1'b0; pr = 1'b0;
    pc = '0; pi = '0;
    for (int cyc = 0; cyc < max_cyc && !fin; cyc++) begin
      if (pv && !pr) begin
        chk("hold_valid", 32'(coef_valid), 32'd1);
        chk("hold_coef", 32'(coef), 32'(pc));
        chk("hold_idx", 32'(coef_idx), 32'(pi));
      end
      chk("no_early_done", 32'(done), 32'd0);
      start = noise && busy && !blk_ready;
      if (blk_ready && src.size() > 0) begin
        blk_valid = 1'b1;
        blk = src[0];
      end else if (noise && !blk_ready) begin
        blk_valid = 1'b1;
        blk = '0;
      end else begin
        blk_valid = 1'b0;
      end
      coef_ready = ($urandom_range(0, 99) < pct);
      if (coef_valid && coef_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_coef", 32'(coef_valid), 32'd0);
        end else begin
          chk("coef", 32'(coef), 32'(expq[0]));
          chk("idx", 32'(coef_idx), 32'(nidx & 255));
          void'(expq.pop_front());
        end
        nidx++;
        hs++;
      end
      pv = coef_valid; pr = coef_ready;
      pc = coef; pi = coef_idx;
      took = blk_ready && blk_valid;
      tick();
      if (took) void'(src.pop_front());
      blk_valid = 1'b0;
      start = 1'b0;
      if (hs == stop_n) begin
        fin = 1'b1;
      end else if (nidx == 256) begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        fin = 1'b1;
      end
    end
    chk("stream_finished", 32'(fin), 32'd1);
    coef_ready = 1'b0;
  endtask

  initial begin
    int lowcnt;
    int seen;
    int rise;
    logic [1343:0] b;

    rst = 1'b1; start = 1'b0; blk_valid = 1'b0;
    blk = '0; coef_ready = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    rst = 1'b0;
    tick();
    chk_zero("idle");

    // All-zero blocks: 112 + 112 + 32 zeros.
    new_poly();
    for (int i = 0; i < 4; i++) src.push_back('0);
    for (int i = 0; i < 256; i++) expq.push_back(12'd0);
    start_poly();
    stream(100, 1000, 1'b0, 2000);
    chk("zero_blocks_left", 32'(src.size()), 32'd1);
    chk("zero_all_coefs", 32'(nidx), 32'd256);
    rise = 0;
    for (int i = 0; i < 20; i++) begin
      if (blk_ready) rise++;
      tick();
    end
    chk("zero_no_ready_after", 32'(rise), 32'd0);

    // All-0xFF block: every candidate is 4095.
    new_poly();
    start_poly();
    coef_ready = 1'b1;
    blk = '1;
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    lowcnt = 0;
    seen = 0;
    for (int i = 0; i < 200 && !blk_ready; i++) begin
      if (coef_valid) seen++;
      lowcnt++;
      tick();
    end
    chk("ff_ready_gap", 32'(lowcnt), 32'd112);
    chk("ff_no_valid", 32'(seen), 32'd0);
    chk("ff_busy", 32'(busy), 32'd1);
    do_reset();

    // Boundary triplets, rest of the block 0xFF.
    b = '1;
    b[23:0]  = 24'hD00D00;
    b[47:24] = 24'hD00D01;
    b[71:48] = 24'hD02D01;
    start_poly();
    coef_ready = 1'b1;
    blk = b;
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
    chk("bnd_k0_valid", 32'(coef_valid), 32'd1);
    chk("bnd_k0_coef", 32'(coef), 32'd3328);
    chk("bnd_k0_idx", 32'(coef_idx), 32'd0);
    tick();
    chk("bnd_k1_valid", 32'(coef_valid), 32'd1);
    chk("bnd_k1_coef", 32'(coef), 32'd3328);
    chk("bnd_k1_idx", 32'(coef_idx), 32'd1);
    tick();
    chk("bnd_k2_reject", 32'(coef_valid), 32'd0);
    tick();
    chk("bnd_k3_valid", 32'(coef_valid), 32'd1);
    chk("bnd_k3_coef", 32'(coef), 32'd3328);
    chk("bnd_k3_idx", 32'(coef_idx), 32'd2);
    tick();
    chk("bnd_k4_reject", 32'(coef_valid), 32'd0);
    tick();
    chk("bnd_k5_reject", 32'(coef_valid), 32'd0);
    seen = 0;
    for (int i = 0; i < 106; i++) begin
      tick();
      if (coef_valid || blk_ready) seen++;
    end
    chk("bnd_tail_quiet", 32'(seen), 32'd0);
    tick();
    chk("bnd_ready_back", 32'(blk_ready), 32'd1);
    do_reset();

    // Backpressure at 30% ready, random blocks.
    new_poly();
    for (int i = 0; i < 6; i++) begin
      src.push_back(rand_blk());
      model_push(src[i]);
    end
    start_poly();
    stream(30, 1000, 1'b0, 6000);
    chk("bp_all_coefs", 32'(nidx), 32'd256);
    chk("bp_model_empty", 32'(expq.size()), 32'd0);

    // Reset after the 100th handshake.
    new_poly();
    for (int i = 0; i < 6; i++) begin
      src.push_back(rand_blk());
      model_push(src[i]);
    end
    start_poly();
    stream(70, 100, 1'b0, 3000);
    chk("mid_n", 32'(nidx), 32'd100);
    chk("mid_busy", 32'(busy), 32'd1);
    do_reset();
    chk_zero("mid_reset");
    tick();
    chk_zero("mid_after");

    // Restart after the abort begins at idx 0.
    new_poly();
    for (int i = 0; i < 3; i++) src.push_back('0);
    for (int i = 0; i < 256; i++) expq.push_back(12'd0);
    start_poly();
    stream(100, 1000, 1'b0, 2000);
    chk("restart_all", 32'(nidx), 32'd256);

    // start/blk_valid noise while parsing.
    new_poly();
    for (int i = 0; i < 6; i++) begin
      src.push_back(rand_blk());
      model_push(src[i]);
    end
    start_poly();
    stream(100, 1000, 1'b1, 3000);
    chk("noise_all", 32'(nidx), 32'd256);
    chk("noise_model_empty", 32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
